// File: rtl/tia_hsync_sequencer.sv
// TIA horizontal timing: /4 colour-clock divider, s1/s2 step strobes, 6-bit LFSR
// line counter with RSYNC/WSYNC handling and registered HSYNC/HBLANK decode.
module tia_hsync_sequencer #(
  parameter int unsigned LINE_STEPS = 57,
  parameter int unsigned HSYNC_ON   = 4,
  parameter int unsigned HSYNC_OFF  = 8,
  parameter int unsigned HBLANK_OFF = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rsync,
  input  logic       wsync,
  output logic [5:0] hcount,
  output logic [1:0] phase,
  output logic       s1,
  output logic       s2,
  output logic       hsync,
  output logic       hblank,
  output logic       line_start,
  output logic       rdy
);

  function automatic logic [5:0] lfsr_step(input logic [5:0] cur);
    return {cur[1] ^ ~cur[0], cur[5:1]};
  endfunction

  function automatic logic [5:0] lfsr_at(input int unsigned n);
    logic [5:0] s;
    s = '0;
    for (int unsigned i = 0; i < n; i++) s = lfsr_step(s);
    return s;
  endfunction

  localparam logic [5:0] WRAP_STATE       = lfsr_at(LINE_STEPS - 1);
  localparam logic [5:0] HSYNC_ON_STATE   = lfsr_at(HSYNC_ON);
  localparam logic [5:0] HSYNC_OFF_STATE  = lfsr_at(HSYNC_OFF);
  localparam logic [5:0] HBLANK_OFF_STATE = lfsr_at(HBLANK_OFF);
  localparam logic [5:0] LOCKUP_STATE     = '1;

  typedef enum logic {RUN, WAIT_LINE} wsync_state_t;

  logic [1:0]   phase_r, phase_nx;
  logic [5:0]   hcount_r, hcount_nx;
  logic         hsync_r, hsync_nx;
  logic         hblank_r, hblank_nx;
  logic         line_start_r, line_start_nx;
  logic         s1_r, s2_r;
  logic         pend_r, pend_nx;
  logic         commit;
  wsync_state_t wstate, wstate_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r      <= '0;
      hcount_r     <= '0;
      hsync_r      <= 1'b0;
      hblank_r     <= 1'b1;
      line_start_r <= 1'b0;
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      pend_r       <= 1'b0;
      wstate       <= RUN;
    end else begin
      phase_r      <= phase_nx;
      hcount_r     <= hcount_nx;
      hsync_r      <= hsync_nx;
      hblank_r     <= hblank_nx;
      line_start_r <= line_start_nx;
      s1_r         <= (phase_nx == 2'd1);
      s2_r         <= (phase_nx == 2'd3);
      pend_r       <= pend_nx;
      wstate       <= wstate_nx;
    end
  end

  always_comb begin
    commit        = (phase_r == 2'd3);
    phase_nx      = phase_r + 2'd1;
    hcount_nx     = hcount_r;
    hsync_nx      = hsync_r;
    hblank_nx     = hblank_r;
    line_start_nx = 1'b0;
    pend_nx       = pend_r | rsync;
    if (commit) begin
      pend_nx = 1'b0;
      if (pend_r || rsync || hcount_r == WRAP_STATE || hcount_r == LOCKUP_STATE)
        hcount_nx = '0;
      else
        hcount_nx = lfsr_step(hcount_r);
      // Decode tracks the state being loaded so hsync/hblank stay aligned with hcount.
      if (hcount_nx == '0) begin
        line_start_nx = 1'b1;
        hsync_nx      = 1'b0;
        hblank_nx     = 1'b1;
      end else begin
        if (hcount_nx == HSYNC_ON_STATE)   hsync_nx  = 1'b1;
        if (hcount_nx == HSYNC_OFF_STATE)  hsync_nx  = 1'b0;
        if (hcount_nx == HBLANK_OFF_STATE) hblank_nx = 1'b0;
      end
    end
  end

  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      RUN:       if (wsync) wstate_nx = WAIT_LINE;
      WAIT_LINE: if (line_start_nx) wstate_nx = RUN;
      default:   wstate_nx = RUN;
    endcase
  end

  assign hcount     = hcount_r;
  assign phase      = phase_r;
  assign s1         = s1_r;
  assign s2         = s2_r;
  assign hsync      = hsync_r;
  assign hblank     = hblank_r;
  assign line_start = line_start_r;
  assign rdy        = (wstate == RUN);

endmodule

// File: tb/tb_tia_hsync_sequencer.sv
// Directed bench for tia_hsync_sequencer: cycle model feeds a scoreboard queue,
// plus explicit timing measurements for sync, blank, line period and WSYNC.
module tb_tia_hsync_sequencer;

  localparam int LINE_STEPS = 57;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rsync = 1'b0;
  logic       wsync = 1'b0;
  logic [5:0] hcount;
  logic [1:0] phase;
  logic       s1, s2, hsync, hblank, line_start, rdy;

  always #5 clk = ~clk;

  tia_hsync_sequencer #(
    .LINE_STEPS(57),
    .HSYNC_ON  (4),
    .HSYNC_OFF (8),
    .HBLANK_OFF(17)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rsync     (rsync),
    .wsync     (wsync),
    .hcount    (hcount),
    .phase     (phase),
    .s1        (s1),
    .s2        (s2),
    .hsync     (hsync),
    .hblank    (hblank),
    .line_start(line_start),
    .rdy       (rdy)
  );

  typedef struct packed {
    logic [5:0] hcount;
    logic [1:0] phase;
    logic       s1, s2, hsync, hblank, line_start, rdy;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass = 0;
  int   n_checks = 0;

  logic [5:0] tbl[LINE_STEPS];
  int  m_phase, m_idx;
  bit  m_lock, m_pend, m_rdy, m_hsync, m_hblank, m_ls;

  int  cyc = 0, ls_cyc = -1, last_period = 0, ls_count = 0;
  int  hs_rise_cyc = 0, hs_rise = 0, hs_width = 0, hb_width = 0;
  int  rdy_fall_cyc = 0, rdy_low = 0;
  bit  prev_hsync = 1'b0, prev_hblank = 1'b1, prev_rdy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [5:0] ref_step(input logic [5:0] s);
    return {~(s[1] ^ s[0]), s[5:1]};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_lock = 0; m_pend = 0;
    m_rdy = 1; m_hsync = 0; m_hblank = 1; m_ls = 0;
  endtask

  task automatic model_step(input bit rs, input bit ws);
    bit ls;
    ls = 1'b0;
    if (m_phase == 3) begin
      if (m_pend || rs || m_lock || m_idx == LINE_STEPS - 1) begin
        m_idx = 0; m_lock = 0; ls = 1'b1;
      end else begin
        m_idx++;
      end
      m_pend   = 1'b0;
      m_hsync  = (m_idx >= 4 && m_idx < 8);
      m_hblank = (m_idx < 17);
    end else begin
      m_pend = m_pend | rs;
    end
    if (m_rdy && ws) m_rdy = 1'b0;
    else if (ls) m_rdy = 1'b1;
    m_phase = (m_phase + 1) % 4;
    m_ls = ls;
  endtask

  task automatic step(input bit rs, input bit ws);
    obs_t e;
    rsync = rs;
    wsync = ws;
    model_step(rs, ws);
    e.hcount     = m_lock ? 6'h3F : tbl[m_idx];
    e.phase      = 2'(m_phase);
    e.s1         = (m_phase == 1);
    e.s2         = (m_phase == 3);
    e.hsync      = m_hsync;
    e.hblank     = m_hblank;
    e.line_start = m_ls;
    e.rdy        = m_rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rsync = 1'b0;
    wsync = 1'b0;
    cyc++;
    e = exp_q.pop_front();
    chk("hcount", 32'(hcount), 32'(e.hcount));
    chk("phase", 32'(phase), 32'(e.phase));
    chk("s1", 32'(s1), 32'(e.s1));
    chk("s2", 32'(s2), 32'(e.s2));
    chk("hsync", 32'(hsync), 32'(e.hsync));
    chk("hblank", 32'(hblank), 32'(e.hblank));
    chk("line_start", 32'(line_start), 32'(e.line_start));
    chk("rdy", 32'(rdy), 32'(e.rdy));
    if (line_start === 1'b1) begin
      if (ls_cyc >= 0) last_period = cyc - ls_cyc;
      ls_cyc = cyc;
      ls_count++;
    end
    if (hsync && !prev_hsync) begin hs_rise_cyc = cyc; hs_rise = cyc - ls_cyc; end
    if (!hsync && prev_hsync) hs_width = cyc - hs_rise_cyc;
    if (!hblank && prev_hblank) hb_width = cyc - ls_cyc;
    if (!rdy && prev_rdy) rdy_fall_cyc = cyc;
    if (rdy && !prev_rdy) rdy_low = cyc - rdy_fall_cyc;
    prev_hsync = hsync; prev_hblank = hblank; prev_rdy = rdy;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hcount"}, 32'(hcount), 32'h00);
    chk({tag, "_phase"}, 32'(phase), 32'h0);
    chk({tag, "_s1"}, 32'(s1), 32'h0);
    chk({tag, "_s2"}, 32'(s2), 32'h0);
    chk({tag, "_hsync"}, 32'(hsync), 32'h0);
    chk({tag, "_hblank"}, 32'(hblank), 32'h1);
    chk({tag, "_line_start"}, 32'(line_start), 32'h0);
    chk({tag, "_rdy"}, 32'(rdy), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] first[7];
    bit         seen[64];
    int         distinct, ls_before;

    first = '{6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h1F, 6'h2F};
    tbl[0] = 6'h00;
    for (int i = 1; i < LINE_STEPS; i++) tbl[i] = ref_step(tbl[i-1]);
    model_reset();

    // reset held across edges
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;

    // free-run from reset: strobes and first commit values
    for (int i = 1; i <= 32; i++) begin
      step(0, 0);
      if (i % 4 == 0 && i / 4 <= 7) chk("commit_seq", 32'(hcount), 32'(first[i/4 - 1]));
    end

    // three free-running lines
    for (int i = 0; i < 3 * 228; i++) step(0, 0);
    chk("line_period", last_period, 228);
    chk("hsync_offset", hs_rise, 16);
    chk("hsync_width", hs_width, 16);
    chk("hblank_width", hb_width, 68);

    // distinct states within one line
    for (int b = 0; b < 300 && line_start !== 1'b1; b++) step(0, 0);
    foreach (seen[i]) seen[i] = 1'b0;
    for (int k = 0; k < LINE_STEPS; k++) begin
      seen[hcount] = 1'b1;
      repeat (4) step(0, 0);
    end
    distinct = 0;
    foreach (seen[i]) if (seen[i]) distinct++;
    chk("distinct_states", distinct, LINE_STEPS);

    // rsync at step index 30
    for (int b = 0; b < 300 && !(m_idx == 30 && m_phase == 1); b++) step(0, 0);
    chk("rsync_at_idx30", 32'(hcount), 32'(tbl[30]));
    step(1, 0);
    step(0, 0);
    step(0, 0);
    chk("rsync_hcount", 32'(hcount), 32'h00);
    chk("rsync_line_start", 32'(line_start), 32'h1);
    repeat (228) step(0, 0);
    chk("rsync_next_line", 32'(line_start), 32'h1);
    chk("rsync_period", last_period, 228);

    // two rsync strobes inside one commit window
    repeat (40) step(0, 0);
    for (int b = 0; b < 8 && m_phase != 0; b++) step(0, 0);
    ls_before = ls_count;
    step(1, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    repeat (4) step(0, 0);
    chk("double_rsync_pulses", ls_count - ls_before, 1);

    // wsync mid-line
    for (int b = 0; b < 300 && !(m_idx == 10 && m_phase == 1); b++) step(0, 0);
    step(0, 1);
    chk("wsync_rdy_low", 32'(rdy), 32'h0);
    for (int b = 0; b < 300 && line_start !== 1'b1; b++) step(0, 0);
    chk("wsync_release", 32'(rdy), 32'h1);

    // wsync coincident with a line_start commit
    for (int b = 0; b < 300 && !(m_idx == LINE_STEPS - 1 && m_phase == 3); b++) step(0, 0);
    step(0, 1);
    chk("wsync_coinc_ls", 32'(line_start), 32'h1);
    chk("wsync_coinc_rdy", 32'(rdy), 32'h0);
    repeat (228) step(0, 0);
    chk("wsync_full_line_rdy", 32'(rdy), 32'h1);
    chk("wsync_full_line_len", rdy_low, 228);

    // backdoor lockup state recovery
    for (int b = 0; b < 300 && !(m_idx == 20 && m_phase == 1); b++) step(0, 0);
    force dut.hcount_r = 6'h3F;
    #1;
    release dut.hcount_r;
    m_lock = 1'b1;
    chk("lockup_loaded", 32'(hcount), 32'h3F);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    chk("lockup_recover", 32'(hcount), 32'h00);
    chk("lockup_line_start", 32'(line_start), 32'h1);
    repeat (4) step(0, 0);
    chk("lockup_next", 32'(hcount), 32'h20);

    // async reset mid-line with wsync and rsync pending
    for (int b = 0; b < 300 && !(m_idx == 25 && m_phase == 0); b++) step(0, 0);
    step(0, 1);
    step(1, 0);
    chk("pre_reset_rdy", 32'(rdy), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    prev_rdy = 1'b1; prev_hsync = 1'b0; prev_hblank = 1'b1;
    repeat (4) step(0, 0);
    chk("post_reset_commit1", 32'(hcount), 32'h20);
    repeat (4) step(0, 0);
    chk("post_reset_commit2", 32'(hcount), 32'h30);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
